execute_stage: RTL and testbench

- Execute (ALU) stage of the pipelined MIPS, directly upstream of the memory stage.
- Consumes decoded operands, applies EX/MEM and MEM/WB forwarding, and computes ADD/ADDIU/LW-address results in a single cycle.
- Runs MUL on an iterative multi-cycle multiplier, stalling decode while it runs.
- Registers {inst_type, target, result} for the memory stage.

---
 rtl/exe_pkg.sv | 26 ++
 rtl/mul_iter.sv | 70 +++++++
 rtl/execute_stage.sv | 205 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared instruction-type codes, FSM state type and immediate
//               sign-extension helper for the execute stage.
// Revision    : 1.0  initial release
// ============================================================================
package exe_pkg;

    localparam logic [2:0] INST_NOP   = 3'd0;
    localparam logic [2:0] INST_ADD   = 3'd1;
    localparam logic [2:0] INST_ADDIU = 3'd2;
    localparam logic [2:0] INST_MUL   = 3'd3;
    localparam logic [2:0] INST_LW    = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } exe_state_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier producing the low 32 bits of
//               a*b, retiring MUL_BITS_PER_CYCLE multiplier bits per cycle.
// Revision    : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int MUL_BITS_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] product_lo
);

    localparam int         c_ITERS = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [5:0] c_LAST  = 6'(c_ITERS - 1);

    logic        r_active;
    logic [5:0]  r_count;
    logic [31:0] r_acc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] w_acc_next;

    // The final chunk is folded in combinationally so the product is ready
    // in the same cycle the counter hits zero.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (r_b[i]) begin
                w_acc_next = w_acc_next + (r_a << i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= 6'd0;
            r_acc    <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
        end else if (start) begin
            r_active <= 1'b1;
            r_count  <= c_LAST;
            r_acc    <= 32'd0;
            r_a      <= a;
            r_b      <= b;
        end else if (r_active) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << MUL_BITS_PER_CYCLE;
            r_b   <= r_b >> MUL_BITS_PER_CYCLE;
            if (r_count == 6'd0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - 6'd1;
            end
        end
    end

    assign done       = r_active && (r_count == 6'd0);
    assign product_lo = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : MIPS execute stage with EX/MEM and MEM/WB forwarding, load-use
//               stall, single-cycle add/address ops and iterative MUL.
//               Optional macro EXE_OVF_TRAP_EN squashes signed-overflow ADD/ADDIU.
// Revision    : 1.0  initial release
// ============================================================================
module execute_stage
    import exe_pkg::*;
#(
    parameter int MUL_BITS_PER_CYCLE = 8
) (
    input  logic        exe_clk_x70,
    input  logic        exe_rst_x70,
    input  logic        valid_in_x70,
    input  logic [2:0]  inst_type_in_x70,
    input  logic [4:0]  rs_x70,
    input  logic [4:0]  rt_x70,
    input  logic [4:0]  target_in_x70,
    input  logic [31:0] src_a_x70,
    input  logic [31:0] src_b_x70,
    input  logic [15:0] imm_x70,
    input  logic [31:0] mw_fwd_tapout_value_x70,
    input  logic [4:0]  mw_fwd_tapout_target_x70,
    input  logic        mw_fwd_en_x70,
    output logic [2:0]  inst_type_x70,
    output logic [4:0]  target_x70,
    output logic [31:0] result_x70,
    output logic        stall_x70,
    output logic        ovf_x70
);

    exe_state_t  r_state;
    exe_state_t  w_state_next;
    logic [2:0]  r_inst_type;
    logic [4:0]  r_target;
    logic [31:0] r_result;
    logic [4:0]  r_mul_target;

    logic [2:0]  w_type_next;
    logic [4:0]  w_target_next;
    logic [31:0] w_result_next;
    logic        w_stall;
    logic        w_mul_start;
    logic        w_mul_done;
    logic [31:0] w_mul_product;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_b;
    logic [31:0] w_sum;
    logic        w_exmem_fwd_ok;
    logic        w_mw_fwd_ok;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_hazard;

    assign w_exmem_fwd_ok = (r_inst_type == INST_ADD || r_inst_type == INST_ADDIU ||
                             r_inst_type == INST_MUL) && (r_target != 5'd0);
    assign w_mw_fwd_ok    = mw_fwd_en_x70 && (mw_fwd_tapout_target_x70 != 5'd0);

    always_comb begin
        w_op_a = src_a_x70;
        if (w_exmem_fwd_ok && r_target == rs_x70) begin
            w_op_a = r_result;
        end else if (w_mw_fwd_ok && mw_fwd_tapout_target_x70 == rs_x70) begin
            w_op_a = mw_fwd_tapout_value_x70;
        end
    end

    always_comb begin
        w_op_b = src_b_x70;
        if (w_exmem_fwd_ok && r_target == rt_x70) begin
            w_op_b = r_result;
        end else if (w_mw_fwd_ok && mw_fwd_tapout_target_x70 == rt_x70) begin
            w_op_b = mw_fwd_tapout_value_x70;
        end
    end

    // A load's data only exists in the memory stage, so a dependent op waits a cycle.
    assign w_uses_rs = valid_in_x70 && (inst_type_in_x70 >= INST_ADD) &&
                       (inst_type_in_x70 <= INST_LW);
    assign w_uses_rt = valid_in_x70 && (inst_type_in_x70 == INST_ADD ||
                                        inst_type_in_x70 == INST_MUL);
    assign w_hazard  = (r_inst_type == INST_LW) && (r_target != 5'd0) &&
                       ((w_uses_rs && r_target == rs_x70) ||
                        (w_uses_rt && r_target == rt_x70));

    assign w_alu_b = (inst_type_in_x70 == INST_ADD) ? w_op_b : sext16(imm_x70);
    assign w_sum   = w_op_a + w_alu_b;

`ifdef EXE_OVF_TRAP_EN
    logic w_ovf;
    logic w_trap;
    logic r_ovf;
    assign w_ovf = (w_op_a[31] == w_alu_b[31]) && (w_sum[31] != w_op_a[31]);
`endif

    always_comb begin
        w_state_next  = r_state;
        w_stall       = 1'b0;
        w_mul_start   = 1'b0;
        w_type_next   = INST_NOP;
        w_target_next = 5'd0;
        w_result_next = 32'd0;
`ifdef EXE_OVF_TRAP_EN
        w_trap        = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                end else if (valid_in_x70) begin
                    case (inst_type_in_x70)
                        INST_ADD, INST_ADDIU, INST_LW: begin
                            w_type_next   = inst_type_in_x70;
                            w_target_next = target_in_x70;
                            w_result_next = w_sum;
`ifdef EXE_OVF_TRAP_EN
                            if (inst_type_in_x70 != INST_LW && w_ovf) begin
                                w_trap        = 1'b1;
                                w_type_next   = INST_NOP;
                                w_target_next = 5'd0;
                            end
`endif
                        end
                        INST_MUL: begin
                            w_mul_start  = 1'b1;
                            w_stall      = 1'b1;
                            w_state_next = ST_MUL_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_BUSY: begin
                if (w_mul_done) begin
                    w_type_next   = INST_MUL;
                    w_target_next = r_mul_target;
                    w_result_next = w_mul_product;
                    w_state_next  = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge exe_clk_x70) begin
        if (exe_rst_x70) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge exe_clk_x70) begin
        if (exe_rst_x70) begin
            r_inst_type  <= INST_NOP;
            r_target     <= 5'd0;
            r_result     <= 32'd0;
            r_mul_target <= 5'd0;
        end else begin
            r_inst_type <= w_type_next;
            r_target    <= w_target_next;
            r_result    <= w_result_next;
            if (w_mul_start) begin
                r_mul_target <= target_in_x70;
            end
        end
    end

`ifdef EXE_OVF_TRAP_EN
    always_ff @(posedge exe_clk_x70) begin
        if (exe_rst_x70) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_trap;
        end
    end
    assign ovf_x70 = r_ovf;
`else
    assign ovf_x70 = 1'b0;
`endif

    mul_iter #(
        .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_mul_iter (
        .clk       (exe_clk_x70),
        .rst       (exe_rst_x70),
        .start     (w_mul_start),
        .a         (w_op_a),
        .b         (w_op_b),
        .done      (w_mul_done),
        .product_lo(w_mul_product)
    );

    assign inst_type_x70 = r_inst_type;
    assign target_x70    = r_target;
    assign result_x70    = r_result;
    assign stall_x70     = w_stall && !exe_rst_x70;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Random program stimulus against an architectural register
//               model; a memory/writeback environment feeds the forward tap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_execute_stage;
    import exe_pkg::*;

    localparam int BPC        = 8;
    localparam int MUL_STALLS = 32 / BPC;
`ifdef EXE_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        exe_clk_x70 = 1'b0;
    logic        exe_rst_x70;
    logic        valid_in_x70;
    logic [2:0]  inst_type_in_x70;
    logic [4:0]  rs_x70;
    logic [4:0]  rt_x70;
    logic [4:0]  target_in_x70;
    logic [31:0] src_a_x70;
    logic [31:0] src_b_x70;
    logic [15:0] imm_x70;
    logic [31:0] mw_fwd_tapout_value_x70;
    logic [4:0]  mw_fwd_tapout_target_x70;
    logic        mw_fwd_en_x70;
    logic [2:0]  inst_type_x70;
    logic [4:0]  target_x70;
    logic [31:0] result_x70;
    logic        stall_x70;
    logic        ovf_x70;

    execute_stage #(.MUL_BITS_PER_CYCLE(BPC)) dut (
        .exe_clk_x70             (exe_clk_x70),
        .exe_rst_x70             (exe_rst_x70),
        .valid_in_x70            (valid_in_x70),
        .inst_type_in_x70        (inst_type_in_x70),
        .rs_x70                  (rs_x70),
        .rt_x70                  (rt_x70),
        .target_in_x70           (target_in_x70),
        .src_a_x70               (src_a_x70),
        .src_b_x70               (src_b_x70),
        .imm_x70                 (imm_x70),
        .mw_fwd_tapout_value_x70 (mw_fwd_tapout_value_x70),
        .mw_fwd_tapout_target_x70(mw_fwd_tapout_target_x70),
        .mw_fwd_en_x70           (mw_fwd_en_x70),
        .inst_type_x70           (inst_type_x70),
        .target_x70              (target_x70),
        .result_x70              (result_x70),
        .stall_x70               (stall_x70),
        .ovf_x70                 (ovf_x70)
    );

    always #5 exe_clk_x70 = ~exe_clk_x70;

    typedef struct packed {
        logic [2:0]  t;
        logic [4:0]  tg;
        logic [31:0] r;
        logic        ov;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] arch[32];
    logic [31:0] rf[32];
    logic        mw_en;
    logic [4:0]  mw_tgt;
    logic [31:0] mw_val;
    logic [2:0]  ex_t;
    logic [4:0]  ex_tg;
    logic [31:0] ex_r;
    logic        stall_s;
    logic [4:0]  prev_lw_tgt;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Monitor: every non-bubble output must match the oldest expectation.
    always @(negedge exe_clk_x70) begin
        if (mon_en) begin
            checks++;
            if (inst_type_x70 != INST_NOP || ovf_x70) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output type=%0d target=%0d result=%h ovf=%0d required=none",
                             inst_type_x70, target_x70, result_x70, ovf_x70);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (inst_type_x70 != mon_e.t || target_x70 != mon_e.tg ||
                        result_x70 != mon_e.r || ovf_x70 != mon_e.ov) begin
                        errors++;
                        $display("FAIL output actual type=%0d target=%0d result=%h ovf=%0d required type=%0d target=%0d result=%h ovf=%0d",
                                 inst_type_x70, target_x70, result_x70, ovf_x70,
                                 mon_e.t, mon_e.tg, mon_e.r, mon_e.ov);
                    end
                end
            end else if (target_x70 != 5'd0 || result_x70 != 32'd0) begin
                errors++;
                $display("FAIL bubble actual target=%0d result=%h required 0/0", target_x70, result_x70);
            end
        end
    end

    // One clock: drive sources from the register file, run the mem/wb environment.
    task automatic step();
        src_a_x70                = rf[rs_x70];
        src_b_x70                = rf[rt_x70];
        mw_fwd_en_x70            = mw_en;
        mw_fwd_tapout_target_x70 = mw_tgt;
        mw_fwd_tapout_value_x70  = mw_val;
        @(negedge exe_clk_x70);
        stall_s = stall_x70;
        ex_t    = inst_type_x70;
        ex_tg   = target_x70;
        ex_r    = result_x70;
        @(posedge exe_clk_x70);
        #1;
        if (mw_en && mw_tgt != 5'd0) rf[mw_tgt] = mw_val;
        mw_en  = (ex_t >= INST_ADD) && (ex_t <= INST_LW);
        mw_tgt = ex_tg;
        mw_val = (ex_t == INST_LW) ? mem_data(ex_r) : ex_r;
    endtask

    task automatic issue(input logic v, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] tg, input logic [15:0] imm);
        logic        real_op;
        logic        haz;
        logic        trap;
        int          exp_stall;
        int          seen;
        longint      wide;
        logic [31:0] s;
        exp_t        e;
        real_op = v && (op >= INST_ADD) && (op <= INST_LW);
        if (!real_op) begin
            rs = 5'd0;
            rt = 5'd0;
        end
        haz = real_op && prev_lw_tgt != 5'd0 &&
              (rs == prev_lw_tgt || ((op == INST_ADD || op == INST_MUL) && rt == prev_lw_tgt));
        exp_stall = (haz ? 1 : 0) + ((real_op && op == INST_MUL) ? MUL_STALLS : 0);
        prev_lw_tgt = 5'd0;
        if (real_op) begin
            if (op == INST_MUL)
                wide = longint'($signed(arch[rs])) * longint'($signed(arch[rt]));
            else if (op == INST_ADD)
                wide = longint'($signed(arch[rs])) + longint'($signed(arch[rt]));
            else
                wide = longint'($signed(arch[rs])) + longint'($signed(imm));
            s    = 32'(wide);
            trap = TRAP_EN && (op == INST_ADD || op == INST_ADDIU) &&
                   (wide != longint'($signed(s)));
            if (trap) begin
                e.t = INST_NOP; e.tg = 5'd0; e.r = s; e.ov = 1'b1;
            end else begin
                e.t = op; e.tg = tg; e.r = s; e.ov = 1'b0;
                if (tg != 5'd0) arch[tg] = (op == INST_LW) ? mem_data(s) : s;
                if (op == INST_LW) prev_lw_tgt = tg;
            end
            exp_q.push_back(e);
        end
        valid_in_x70     = v;
        inst_type_in_x70 = op;
        rs_x70           = rs;
        rt_x70           = rt;
        target_in_x70    = tg;
        imm_x70          = imm;
        seen = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (!stall_s) break;
            seen++;
        end
        checks++;
        if (seen != exp_stall) begin
            errors++;
            $display("FAIL stall_cycles op=%0d actual=%0d required=%0d", op, seen, exp_stall);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (inst_type_x70 != 3'd0 || target_x70 != 5'd0 || result_x70 != 32'd0 ||
            stall_x70 != 1'b0 || ovf_x70 != 1'b0) begin
            errors++;
            $display("FAIL %s actual type=%0d target=%0d result=%h stall=%0d ovf=%0d required all 0",
                     tag, inst_type_x70, target_x70, result_x70, stall_x70, ovf_x70);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = $urandom;
        arch[0]  = 32'd0;
        arch[1]  = 32'd7;
        arch[2]  = 32'hFFFF_FFFD;
        arch[10] = 32'h7FFF_FFF0;
        arch[11] = 32'd1234;
        arch[12] = 32'hFFFF_FFC8;
        for (int i = 0; i < 32; i++) rf[i] = arch[i];
        mw_en = 1'b0; mw_tgt = 5'd0; mw_val = 32'd0;
        prev_lw_tgt = 5'd0;
        exe_rst_x70 = 1'b1;
        valid_in_x70 = 1'b0; inst_type_in_x70 = INST_NOP;
        rs_x70 = 5'd0; rt_x70 = 5'd0; target_in_x70 = 5'd0; imm_x70 = 16'd0;
        src_a_x70 = 32'd0; src_b_x70 = 32'd0;
        mw_fwd_en_x70 = 1'b0; mw_fwd_tapout_target_x70 = 5'd0; mw_fwd_tapout_value_x70 = 32'd0;
        repeat (2) @(posedge exe_clk_x70);
        #1;
        check_zero_outputs("reset_state");
        exe_rst_x70 = 1'b0;
        mon_en = 1'b1;

        issue(1'b1, INST_ADD,   5'd1,  5'd2,  5'd3, 16'h0000);
        issue(1'b1, INST_ADDIU, 5'd10, 5'd0,  5'd5, 16'h0020);
        issue(1'b1, INST_MUL,   5'd11, 5'd12, 5'd6, 16'h0000);
        issue(1'b1, INST_ADD,   5'd1,  5'd1,  5'd4, 16'h0000);
        issue(1'b1, INST_ADD,   5'd4,  5'd4,  5'd7, 16'h0000);
        issue(1'b1, INST_ADD,   5'd2,  5'd2,  5'd4, 16'h0000);
        issue(1'b1, INST_NOP,   5'd0,  5'd0,  5'd0, 16'h0000);
        issue(1'b1, INST_ADD,   5'd4,  5'd4,  5'd7, 16'h0000);
        issue(1'b1, INST_LW,    5'd1,  5'd0,  5'd8, 16'h0010);
        issue(1'b1, INST_ADD,   5'd8,  5'd1,  5'd9, 16'h0000);
        issue(1'b1, INST_LW,    5'd9,  5'd0,  5'd6, 16'hFFF0);
        issue(1'b1, INST_MUL,   5'd3,  5'd6,  5'd5, 16'h0000);

        for (int n = 0; n < 300; n++) begin
            issue($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom));
        end

        // Abort a MUL with reset in its second busy cycle.
        valid_in_x70 = 1'b1; inst_type_in_x70 = INST_MUL;
        rs_x70 = 5'd1; rt_x70 = 5'd2; target_in_x70 = 5'd6; imm_x70 = 16'd0;
        step();
        checks++;
        if (stall_s !== 1'b1) begin
            errors++;
            $display("FAIL mul_accept_stall actual=%0d required=1", stall_s);
        end
        step();
        exe_rst_x70 = 1'b1;
        valid_in_x70 = 1'b0; inst_type_in_x70 = INST_NOP;
        rs_x70 = 5'd0; rt_x70 = 5'd0; target_in_x70 = 5'd0;
        step();
        exe_rst_x70 = 1'b0;
        check_zero_outputs("reset_during_mul");
        prev_lw_tgt = 5'd0;
        for (int n = 0; n < 8; n++) issue(1'b0, INST_NOP, 5'd0, 5'd0, 5'd0, 16'h0000);

        for (int n = 0; n < 60; n++) begin
            issue($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom));
        end
        for (int n = 0; n < 4; n++) issue(1'b0, INST_NOP, 5'd0, 5'd0, 5'd0, 16'h0000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual_pending=%0d required=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
